// File: rtl/eink_panel_spi_responder.sv
// Panel-side SPI responder for the e-ink link: oversampled deserialiser, tagged byte FIFO, BUSY model.
// Define EINK_BUSY_MODEL_EN to build the BUSY counter; otherwise o_busy is tied low.
`timescale 1ns/1ps
module eink_panel_spi_responder #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          BUSY_CYCLES = 1000,
    parameter logic [7:0]  ACT_CMD     = 8'h20
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_spi_sclk,
    input  logic       i_spi_csn,
    input  logic       i_spi_dc,
    input  logic       i_spi_mosi,
    output logic       o_busy,
    output logic       o_rd_valid,
    input  logic       i_rd_ready,
    output logic       o_rd_dc,
    output logic [7:0] o_rd_byte,
    output logic       o_overflow,
    output logic       o_frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0] r_sclk_sync, r_csn_sync, r_dc_sync, r_mosi_sync;
    logic       r_sclk_d, r_csn_d, r_armed, r_frame_err, r_overflow;
    logic [2:0] r_bitcnt;
    logic [6:0] r_sr;
    logic [8:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;

    logic w_sclk, w_csn, w_dc, w_mosi;
    logic w_sclk_rise, w_csn_rise, w_csn_fall, w_push;
    logic [7:0] w_push_byte;
    logic w_empty, w_full, w_pop, w_wr, w_drop;

    assign w_sclk      = r_sclk_sync[1];
    assign w_csn       = r_csn_sync[1];
    assign w_dc        = r_dc_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_csn_rise  = w_csn & ~r_csn_d;
    assign w_csn_fall  = ~w_csn & r_csn_d;
    assign w_push_byte = {r_sr, w_mosi};
    // Only a CSn falling edge seen since reset arms the receiver, so a frame cut by reset is never resumed.
    assign w_push      = ~w_csn & ~w_csn_fall & r_armed & w_sclk_rise & (r_bitcnt == 3'd7);

    // CSn syncs reset low so a CSn already low at reset release does not look like a fresh frame start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_csn_sync  <= '0;
            r_dc_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_csn_d     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], i_spi_sclk};
            r_csn_sync  <= {r_csn_sync[0], i_spi_csn};
            r_dc_sync   <= {r_dc_sync[0], i_spi_dc};
            r_mosi_sync <= {r_mosi_sync[0], i_spi_mosi};
            r_sclk_d    <= w_sclk;
            r_csn_d     <= w_csn;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bitcnt    <= '0;
            r_sr        <= '0;
            r_armed     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_csn_rise & (r_bitcnt != 3'd0);
            if (w_csn) begin
                r_bitcnt <= '0;
                r_armed  <= 1'b0;
            end else if (w_csn_fall) begin
                r_bitcnt <= '0;
                r_armed  <= 1'b1;
            end else if (r_armed && w_sclk_rise) begin
                r_sr     <= w_push_byte[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
            end
        end
    end

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = i_rd_ready & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp[AW-1:0]] <= {w_dc, w_push_byte};
                r_wp                <= r_wp + (AW+1)'(1);
            end
            if (w_pop)  r_rp       <= r_rp + (AW+1)'(1);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign o_rd_valid           = ~w_empty;
    assign {o_rd_dc, o_rd_byte} = r_mem[r_rp[AW-1:0]];
    assign o_overflow           = r_overflow;
    assign o_frame_err          = r_frame_err;

`ifdef EINK_BUSY_MODEL_EN
    localparam int CW = $clog2(BUSY_CYCLES) + 1;
    logic [CW-1:0] r_busy_cnt;
    logic          r_busy, w_act;

    // Dropped activation commands still count: the panel reacts to the command, not the FIFO.
    assign w_act = w_push & ~w_dc & (w_push_byte == ACT_CMD);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy     <= 1'b0;
            r_busy_cnt <= '0;
        end else if (w_act) begin
            r_busy     <= 1'b1;
            r_busy_cnt <= CW'(BUSY_CYCLES - 1);
        end else if (r_busy) begin
            if (r_busy_cnt == '0) r_busy     <= 1'b0;
            else                  r_busy_cnt <= r_busy_cnt - CW'(1);
        end
    end
    assign o_busy = r_busy;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{ACT_CMD, BUSY_CYCLES[0]};
    assign o_busy       = 1'b0;
`endif
endmodule

// File: tb/tb_eink_panel_spi_responder.sv
// Self-checking bench for eink_panel_spi_responder: directed scenarios plus random frames against a queue model.
`timescale 1ns/1ps
module tb_eink_panel_spi_responder;
    localparam int         DEPTH = 8;
    localparam int         BCYC  = 48;
    localparam logic [7:0] ACT   = 8'h20;
    localparam int         HP    = 2;

    logic clk = 0, rst_n = 0, sclk = 0, csn = 1, dc = 0, mosi = 0, rd_ready = 0;
    logic busy, rd_valid, rd_dc, overflow, frame_err;
    logic [7:0] rd_byte;
    int checks = 0, errors = 0;
    int fe_cnt = 0, busy_hi = 0;
    bit rand_on = 0;

    always #5 clk = ~clk;

    eink_panel_spi_responder #(.FIFO_DEPTH(DEPTH), .BUSY_CYCLES(BCYC), .ACT_CMD(ACT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_spi_sclk(sclk), .i_spi_csn(csn), .i_spi_dc(dc),
        .i_spi_mosi(mosi), .o_busy(busy), .o_rd_valid(rd_valid), .i_rd_ready(rd_ready),
        .o_rd_dc(rd_dc), .o_rd_byte(rd_byte), .o_overflow(overflow), .o_frame_err(frame_err));

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: pins seen through a two-sample delay, bytes assembled arithmetically, FIFO as a queue.
    logic s1_sclk, s2_sclk, d_sclk, s1_csn, s2_csn, d_csn, s1_dc, s2_dc, s1_mosi, s2_mosi;
    int   m_bits, m_acc, m_busy_rem;
    bit   m_armed, m_ovf, m_fe;
    logic [8:0] mq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1_sclk, s2_sclk, d_sclk, s1_csn, s2_csn, d_csn, s1_dc, s2_dc, s1_mosi, s2_mosi} = '0;
            m_bits = 0; m_acc = 0; m_busy_rem = 0;
            m_armed = 0; m_ovf = 0; m_fe = 0;
            mq.delete();
        end else begin
            bit push, pop;
            push = 0;
            m_fe = 0;
            if (s2_csn) begin
                if (!d_csn && m_bits != 0) m_fe = 1;
                m_bits = 0; m_acc = 0; m_armed = 0;
            end else if (d_csn) begin
                m_armed = 1; m_bits = 0;
            end else if (m_armed && s2_sclk && !d_sclk) begin
                m_acc = (m_acc * 2 + int'(s2_mosi)) % 256;
                m_bits++;
                if (m_bits == 8) begin push = 1; m_bits = 0; end
            end
            pop = rd_ready && mq.size() > 0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() >= DEPTH) m_ovf = 1;
                else mq.push_back({s2_dc, 8'(m_acc)});
            end
`ifdef EINK_BUSY_MODEL_EN
            if (push && !s2_dc && m_acc == int'(ACT)) m_busy_rem = BCYC;
            else if (m_busy_rem > 0) m_busy_rem--;
`endif
            d_sclk = s2_sclk; s2_sclk = s1_sclk; s1_sclk = sclk;
            d_csn = s2_csn;   s2_csn = s1_csn;   s1_csn = csn;
            s2_dc = s1_dc;    s1_dc = dc;
            s2_mosi = s1_mosi; s1_mosi = mosi;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_valid", rd_valid, mq.size() != 0);
            if (mq.size() != 0) chk("cmp_head", {rd_dc, rd_byte}, mq[0]);
            chk("cmp_overflow", overflow, m_ovf);
            chk("cmp_frame_err", frame_err, m_fe);
            chk("cmp_busy", busy, m_busy_rem > 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_cnt++;
            if (busy) busy_hi++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input bit d, input logic [7:0] b, input int n, input bit pop_last = 0);
        dc = d;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            tick(HP);
            sclk = 1;
            if (pop_last && i == 0) begin
                tick(2); rd_ready = 1; tick(1); rd_ready = 0;
            end else tick(HP);
            sclk = 0;
        end
    endtask

    task automatic cs_lo;
        csn = 0; tick(4);
    endtask

    task automatic cs_hi;
        csn = 1; tick(6);
    endtask

    task automatic pop_chk(input logic [8:0] e, input string nm);
        chk({nm, "_v"}, rd_valid, 1);
        chk(nm, {rd_dc, rd_byte}, e);
        rd_ready = 1; tick(1); rd_ready = 0;
    endtask

    task automatic rand_frames(input int n);
        for (int f = 0; f < n; f++) begin
            int nb;
            cs_lo;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                bit d;
                logic [7:0] v;
                d = 1'($urandom_range(0, 1));
                v = ($urandom_range(0, 3) == 0) ? ACT : 8'($urandom);
                send_bits(d, v, 8);
            end
            if ($urandom_range(0, 4) == 0) send_bits(1, 8'($urandom), $urandom_range(1, 7));
            cs_hi;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, b0;
        tick(2);
        chk("rst_busy", busy, 0); chk("rst_valid", rd_valid, 0); chk("rst_dc", rd_dc, 0);
        chk("rst_byte", rd_byte, 0); chk("rst_ovf", overflow, 0); chk("rst_fe", frame_err, 0);
        rst_n = 1; tick(3);

        cs_lo; send_bits(0, 8'h24, 8); send_bits(1, 8'hA5, 8); send_bits(1, 8'h3C, 8); cs_hi;
        chk("t1_model_n", mq.size(), 3);
        chk("t1_model_h", mq[0], 9'h024);
        pop_chk(9'h024, "t1_p0"); pop_chk(9'h1A5, "t1_p1"); pop_chk(9'h13C, "t1_p2");

        cs_lo;
        for (int i = 0; i < 8; i++) send_bits(1, 8'(i), 8);
        send_bits(1, 8'hFF, 8);
        cs_hi;
        chk("t2_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) pop_chk(9'h100 + 9'(i), "t2_pop");
        chk("t2_empty", rd_valid, 0);

        f0 = fe_cnt;
        cs_lo; send_bits(1, 8'hFF, 5); cs_hi;
        chk("t3_fe_pulses", fe_cnt - f0, 1);
        chk("t3_nopush", rd_valid, 0);
        cs_lo; send_bits(1, 8'h81, 8); cs_hi;
        pop_chk(9'h181, "t3_realign");

`ifdef EINK_BUSY_MODEL_EN
        b0 = busy_hi;
        cs_lo; send_bits(0, ACT, 8); cs_hi; tick(60);
        chk("t4_busy_len", busy_hi - b0, BCYC);
        b0 = busy_hi;
        cs_lo; send_bits(1, ACT, 8); cs_hi; tick(60);
        chk("t4_data_nobusy", busy_hi - b0, 0);
        b0 = busy_hi;
        cs_lo; send_bits(0, ACT, 8); send_bits(0, ACT, 8); cs_hi; tick(100);
        chk("t5_retrigger_len", busy_hi - b0, 32 + BCYC);
        pop_chk(9'h020, "t5_p0"); pop_chk(9'h120, "t5_p1");
        pop_chk(9'h020, "t5_p2"); pop_chk(9'h020, "t5_p3");
`else
        b0 = busy_hi;
        cs_lo; send_bits(0, ACT, 8); cs_hi; tick(20);
        chk("t4_busy_tied", busy_hi - b0, 0);
        pop_chk(9'h020, "t4_p0");
`endif

        cs_lo; send_bits(0, ACT, 8); tick(5);
`ifdef EINK_BUSY_MODEL_EN
        chk("t5_busy_pre", busy, 1);
`endif
        send_bits(1, 8'hC3, 3);
        rst_n = 0; #1;
        chk("t5_rst_busy", busy, 0); chk("t5_rst_valid", rd_valid, 0); chk("t5_rst_ovf", overflow, 0);
        tick(2); sclk = 0; rst_n = 1; tick(3);
        send_bits(1, 8'h55, 8); tick(6);
        chk("t5_rearm_wait", rd_valid, 0);
        cs_hi; cs_lo; send_bits(1, 8'h66, 8); cs_hi;
        pop_chk(9'h166, "t5_rearm");

        cs_lo;
        for (int i = 0; i < 8; i++) send_bits(1, 8'h10 + 8'(i), 8);
        send_bits(1, 8'h99, 8, 1);
        cs_hi;
        chk("t6_noovf", overflow, 0);
        for (int i = 1; i < 8; i++) pop_chk(9'h110 + 9'(i), "t6_pop");
        pop_chk(9'h199, "t6_new");
        chk("t6_empty", rd_valid, 0);

        rand_on = 1;
        fork
            begin rand_frames(40); rand_on = 0; end
            begin
                while (rand_on) begin rd_ready = 1'($urandom_range(0, 1)); tick(1); end
                rd_ready = 0;
            end
        join
        tick(BCYC + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
